// File: rtl/dm_responder.sv
// dm_responder: load/store memory responder with configurable latency and sub-word lanes.
// Optional MEM_TRACE_EN prints every successful store at its access edge.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic c_we, c_sign;
  logic [1:0] c_size;
  logic [ADDR_W+1:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] mem [2**ADDR_W];
  logic accept, access, err, wr;
  logic a_we, a_sign;
  logic [1:0] a_size;
  logic [ADDR_W+1:0] a_addr;
  logic [31:0] a_wdata, cur, mask, merged, rdata;
  logic [ADDR_W-1:0] idx;
  logic [4:0] sh;
  logic [15:0] lane;
  // With zero latency the access uses the live request in IDLE, else the captured copy
  always_comb begin
    req_ready = (state == IDLE) && reset;
    accept = req_valid && req_ready;
    access = (state == IDLE && accept && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
    state_nx = state;
    if (state == IDLE && accept) state_nx = (LATENCY == 0) ? RESP : WAIT;
    else if (state == WAIT && cnt == 4'd1) state_nx = RESP;
    else if (state == RESP && rsp_ready) state_nx = IDLE;
    a_we = (state == IDLE) ? req_we : c_we;
    a_sign = (state == IDLE) ? req_sign : c_sign;
    a_size = (state == IDLE) ? req_size : c_size;
    a_addr = (state == IDLE) ? req_addr[ADDR_W+1:0] : c_addr;
    a_wdata = (state == IDLE) ? req_wdata : c_wdata;
    idx = a_addr[ADDR_W+1:2];
    cur = mem[idx];
    sh = (a_size == 2'b00) ? {a_addr[1:0], 3'b000} : {a_addr[1], 4'b0000};
    lane = 16'(cur >> sh);
    mask = (a_size == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
    merged = (a_size == 2'b10) ? a_wdata : (cur & ~mask) | ((a_wdata << sh) & mask);
    err = (a_size == 2'b11) || (a_size == 2'b01 && a_addr[0]) || (a_size == 2'b10 && a_addr[1:0] != 2'b00);
    rdata = (a_we || err) ? 32'h0 :
            (a_size == 2'b00) ? {{24{a_sign & lane[7]}}, lane[7:0]} :
            (a_size == 2'b01) ? {{16{a_sign & lane[15]}}, lane} : cur;
    wr = access && a_we && !err;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      c_we <= 1'b0;
      c_sign <= 1'b0;
      c_size <= 2'b00;
      c_addr <= '0;
      c_wdata <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        c_we <= req_we;
        c_sign <= req_sign;
        c_size <= req_size;
        c_addr <= req_addr[ADDR_W+1:0];
        c_wdata <= req_wdata;
        cnt <= 4'(LATENCY);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rdata;
        rsp_err <= err;
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_mem
    always_ff @(posedge clk or negedge reset)
      if (!reset) mem[i] <= 32'h0;
      else if (wr && idx == ADDR_W'(i)) mem[i] <= merged;
  end
`ifdef MEM_TRACE_EN
  logic [31:0] c_pc;
  logic unused;
  assign unused = ^req_addr[31:ADDR_W+2];
  always_ff @(posedge clk or negedge reset)
    if (!reset) c_pc <= 32'h0;
    else if (accept) c_pc <= req_pc;
  always_ff @(posedge clk)
    if (reset && wr) $display("%d@%h: *%h <= %h", $time, (state == IDLE) ? req_pc : c_pc, {idx, 2'b00}, merged);
`else
  logic unused;
  assign unused = ^{req_pc, req_addr[31:ADDR_W+2]};
`endif
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of dm_responder at latencies 1, 3 and 0.
module tb_dm_responder;
  logic clk = 1'b0, reset = 1'b0;
  logic we = 1'b0, sg = 1'b0;
  logic [1:0] sz = 2'b10;
  logic [31:0] ad = 32'h0, wd = 32'h0, pc = 32'h0;
  logic [2:0] rqv = 3'b000, rqr, rsv, rsr = 3'b000, rse;
  logic [31:0] rsd [3];
  int total = 0, bad = 0;
  logic [31:0] rd;
  logic er;
  int lat;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .req_valid(rqv[0]), .req_ready(rqr[0]),
    .req_we(we), .req_size(sz), .req_sign(sg), .req_addr(ad), .req_wdata(wd), .req_pc(pc),
    .rsp_valid(rsv[0]), .rsp_ready(rsr[0]), .rsp_rdata(rsd[0]), .rsp_err(rse[0]));
  dm_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .req_valid(rqv[1]), .req_ready(rqr[1]),
    .req_we(we), .req_size(sz), .req_sign(sg), .req_addr(ad), .req_wdata(wd), .req_pc(pc),
    .rsp_valid(rsv[1]), .rsp_ready(rsr[1]), .rsp_rdata(rsd[1]), .rsp_err(rse[1]));
  dm_responder #(.ADDR_W(10), .LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .req_valid(rqv[2]), .req_ready(rqr[2]),
    .req_we(we), .req_size(sz), .req_sign(sg), .req_addr(ad), .req_wdata(wd), .req_pc(pc),
    .rsp_valid(rsv[2]), .rsp_ready(rsr[2]), .rsp_rdata(rsd[2]), .rsp_err(rse[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the request bus after accept, optionally stall the response
  task automatic xact(input int u, input logic w, input logic [1:0] s, input logic g,
                      input logic [31:0] a, input logic [31:0] d, input int hold,
                      output logic [31:0] r, output logic e, output int l);
    int n;
    logic [31:0] first;
    @(negedge clk);
    we = w; sz = s; sg = g; ad = a; wd = d; pc = 32'h100 + a; rqv[u] = 1'b1;
    n = 0;
    while (!rqr[u] && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", 32'(rqr[u]), 32'd1);
    @(posedge clk);
    #1 rqv[u] = 1'b0;
    we = ~w; sz = ~s; sg = ~g; ad = ~a; wd = ~d;
    l = 0;
    while (!rsv[u] && l < 30) begin @(posedge clk); #1; l++; end
    chk("rsp_valid", 32'(rsv[u]), 32'd1);
    first = rsd[u];
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsv[u]), 32'd1);
      chk("hold_rdata", rsd[u], first);
      chk("hold_ready", 32'(rqr[u]), 32'd0);
    end
    r = rsd[u]; e = rse[u];
    @(negedge clk); rsr[u] = 1'b1;
    @(posedge clk); #1 rsr[u] = 1'b0;
    chk("rsp_drop", 32'(rsv[u]), 32'd0);
  endtask

  task automatic op(input string tag, input int u, input logic w, input logic [1:0] s, input logic g,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] er_d, input logic er_e, input int er_l);
    xact(u, w, s, g, a, d, 0, rd, er, lat);
    chk({tag, "_rdata"}, rd, er_d);
    chk({tag, "_err"}, 32'(er), 32'(er_e));
    chk({tag, "_lat"}, 32'(lat), 32'(er_l));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready_low", 32'(rqr), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(rqr), 32'b111);
    chk("rst_valid", 32'(rsv), 32'd0);
    chk("rst_rdata", rsd[0], 32'h0);
    chk("rst_err", 32'(rse), 32'd0);
    // reset in the middle of a store's wait
    @(negedge clk);
    we = 1'b1; sz = 2'b10; sg = 1'b0; ad = 32'h0; wd = 32'h11223344; rqv[0] = 1'b1;
    @(posedge clk);
    #1 rqv[0] = 1'b0;
    chk("wait_ready", 32'(rqr[0]), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rqr[0]), 32'd0);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rqr[0]), 32'd1);
    chk("post_rst_valid", 32'(rsv[0]), 32'd0);
    op("lw_after_rst", 0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    op("sw_10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    op("lw_10", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    op("sw_20", 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80017FFE, 32'h0, 1'b0, 1);
    op("lh_22", 0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 1);
    op("lhu_22", 0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, 1);
    op("lh_20", 0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007FFE, 1'b0, 1);
    op("sw_30", 0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1);
    op("sb_31", 0, 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAB, 32'h0, 1'b0, 1);
    op("sh_32", 0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF1234, 32'h0, 1'b0, 1);
    op("lw_30", 0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1234AB00, 1'b0, 1);
    op("lb_31", 0, 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'hFFFFFFAB, 1'b0, 1);
    op("lbu_31", 0, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h000000AB, 1'b0, 1);
    op("sw_04", 0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0BADF00D, 32'h0, 1'b0, 1);
    op("lh_23", 0, 1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 32'h0, 1'b1, 1);
    op("sw_05", 0, 1'b1, 2'b10, 1'b0, 32'h05, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    op("s11_04", 0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1, 1);
    op("lw_04", 0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0BADF00D, 1'b0, 1);
    op("l11_10", 0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    op("sw_00", 0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h55AA55AA, 32'h0, 1'b0, 1);
    op("lw_1000", 0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h55AA55AA, 1'b0, 1);
    op("l3_sw_08", 1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 3);
    xact(1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5, rd, er, lat);
    chk("l3_lw_rdata", rd, 32'hCAFEF00D);
    chk("l3_lw_err", 32'(er), 32'd0);
    chk("l3_lw_lat", 32'(lat), 32'd3);
    op("l0_sw_0c", 2, 1'b1, 2'b10, 1'b0, 32'h0C, 32'h13579BDF, 32'h0, 1'b0, 0);
    op("l0_lw_0c", 2, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h13579BDF, 1'b0, 0);
    op("l0_lh_0e", 2, 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'h00001357, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
